// File: rtl/id_ex_operand_stage_if.sv
// Bundle between the ID stage, the ID/EX operand stage and the EX-side consumers.
// master drives decoded fields and forwarding sources; slave is the operand stage itself.
interface id_ex_operand_stage_if #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic [XLEN-1:0]       id_imm;
  logic [3:0]            id_alu_op;
  logic                  id_alu_src;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_write;
  logic                  id_mem_to_reg;
  logic                  flush;
  logic                  hold;
  logic [REG_ADDR_W-1:0] exmem_rd;
  logic                  exmem_reg_write;
  logic [XLEN-1:0]       exmem_result;
  logic [REG_ADDR_W-1:0] memwb_rd;
  logic                  memwb_reg_write;
  logic [XLEN-1:0]       memwb_data;
  logic [XLEN-1:0]       alu_a;
  logic [XLEN-1:0]       alu_b;
  logic [3:0]            alu_op;
  logic [XLEN-1:0]       ex_store_data;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_valid;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_mem_to_reg;
  logic                  stall;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           flush, hold, exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_data,
    input  alu_a, alu_b, alu_op, ex_store_data, ex_rd, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, stall
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
           id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           flush, hold, exmem_rd, exmem_reg_write, exmem_result,
           memwb_rd, memwb_reg_write, memwb_data,
    output alu_a, alu_b, alu_op, ex_store_data, ex_rd, ex_valid, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_mem_to_reg, stall
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with combinational EX-side operand forwarding and
// load-use hazard detection; flush and load-use both write a zeroed bubble.
module id_ex_operand_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  id_ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic [3:0]            alu_op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
  } ex_fields_t;

  ex_fields_t      ex_q;
  ex_fields_t      ex_d;
  ex_fields_t      id_fields;
  logic            load_use;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  always_comb begin
    id_fields            = '0;
    id_fields.valid      = bus.id_valid;
    id_fields.reg_write  = bus.id_reg_write;
    id_fields.mem_read   = bus.id_mem_read;
    id_fields.mem_write  = bus.id_mem_write;
    id_fields.mem_to_reg = bus.id_mem_to_reg;
    id_fields.alu_src    = bus.id_alu_src;
    id_fields.alu_op     = bus.id_alu_op;
    id_fields.rd         = bus.id_rd;
    id_fields.rs1        = bus.id_rs1;
    id_fields.rs2        = bus.id_rs2;
    id_fields.rs1_data   = bus.id_rs1_data;
    id_fields.rs2_data   = bus.id_rs2_data;
    id_fields.imm        = bus.id_imm;
  end

  assign load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) & bus.id_valid &
                    ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));

  // Reset gating keeps the front end running while the stage is being cleared.
  assign bus.stall = ~reset & (load_use | bus.hold);

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.hold) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else begin
      ex_d = id_fields;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; x0 always reads as zero.
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    if (ex_q.rs1 == '0) begin
      fwd_rs1 = '0;
    end else if (bus.exmem_reg_write && (bus.exmem_rd == ex_q.rs1)) begin
      fwd_rs1 = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd == ex_q.rs1)) begin
      fwd_rs1 = bus.memwb_data;
    end
  end

  always_comb begin
    fwd_rs2 = ex_q.rs2_data;
    if (ex_q.rs2 == '0) begin
      fwd_rs2 = '0;
    end else if (bus.exmem_reg_write && (bus.exmem_rd == ex_q.rs2)) begin
      fwd_rs2 = bus.exmem_result;
    end else if (bus.memwb_reg_write && (bus.memwb_rd == ex_q.rs2)) begin
      fwd_rs2 = bus.memwb_data;
    end
  end

  assign bus.alu_a         = fwd_rs1;
  assign bus.alu_b         = ex_q.alu_src ? ex_q.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.alu_op        = ex_q.alu_op;
  assign bus.ex_rd         = ex_q.rd;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_reg_write  = ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.mem_write;
  assign bus.ex_mem_to_reg = ex_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected EX contents are queued as each
// ID instruction is driven and popped after the capturing clock edge.
module tb_id_ex_operand_stage;
  localparam int XLEN = 64;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic [63:0] imm;
  } ex_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.XLEN(XLEN), .REG_ADDR_W(5)) bus ();

  id_ex_operand_stage #(.XLEN(XLEN), .REG_ADDR_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  ex_t sbQueue[$];
  ex_t cur;
  int  checkCount = 0;
  int  failCount  = 0;

  task automatic checkValue(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  function automatic logic [63:0] modelFwd(input logic [4:0] rs, input logic [63:0] rfData);
    if (rs == 5'd0) return 64'd0;
    if (bus.exmem_reg_write && bus.exmem_rd == rs) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd == rs) return bus.memwb_data;
    return rfData;
  endfunction

  function automatic ex_t mkInstr(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [63:0] d1, input logic [63:0] d2,
                                  input logic [63:0] imm, input logic [3:0] op, input logic src,
                                  input logic rw, input logic mr, input logic mw, input logic m2r);
    ex_t e;
    e.valid = v; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.rs1_data = d1; e.rs2_data = d2; e.imm = imm; e.alu_op = op; e.alu_src = src;
    e.reg_write = rw; e.mem_read = mr; e.mem_write = mw; e.mem_to_reg = m2r;
    return e;
  endfunction

  task automatic setFwd(input logic [4:0] exRd, input logic exRw, input logic [63:0] exRes,
                        input logic [4:0] wbRd, input logic wbRw, input logic [63:0] wbData);
    bus.exmem_rd = exRd; bus.exmem_reg_write = exRw; bus.exmem_result = exRes;
    bus.memwb_rd = wbRd; bus.memwb_reg_write = wbRw; bus.memwb_data = wbData;
  endtask

  // Registered outputs are compared against the entry queued for this edge.
  task automatic checkOutput();
    if (sbQueue.size() == 0) begin
      checkValue("sb_empty", 64'd1, 64'd0);
      return;
    end
    cur = sbQueue.pop_front();
    checkValue("ex_valid", bus.ex_valid, cur.valid);
    checkValue("ex_reg_write", bus.ex_reg_write, cur.reg_write);
    checkValue("ex_mem_read", bus.ex_mem_read, cur.mem_read);
    checkValue("ex_mem_write", bus.ex_mem_write, cur.mem_write);
    checkValue("ex_mem_to_reg", bus.ex_mem_to_reg, cur.mem_to_reg);
    checkValue("ex_rd", bus.ex_rd, cur.rd);
    checkValue("alu_op", bus.alu_op, cur.alu_op);
  endtask

  // Called at a falling edge: drive ID, check current EX operands/stall, queue next EX.
  task automatic applyStimulus(input ex_t s, input logic fl, input logic hd);
    logic loadUse;
    logic [63:0] f1, f2;
    ex_t nxt;
    bus.id_valid = s.valid; bus.id_rd = s.rd; bus.id_rs1 = s.rs1; bus.id_rs2 = s.rs2;
    bus.id_rs1_data = s.rs1_data; bus.id_rs2_data = s.rs2_data; bus.id_imm = s.imm;
    bus.id_alu_op = s.alu_op; bus.id_alu_src = s.alu_src; bus.id_reg_write = s.reg_write;
    bus.id_mem_read = s.mem_read; bus.id_mem_write = s.mem_write; bus.id_mem_to_reg = s.mem_to_reg;
    bus.flush = fl; bus.hold = hd;
    #1;
    loadUse = cur.valid && cur.mem_read && cur.rd != 5'd0 && s.valid &&
              (cur.rd == s.rs1 || cur.rd == s.rs2);
    f1 = modelFwd(cur.rs1, cur.rs1_data);
    f2 = modelFwd(cur.rs2, cur.rs2_data);
    checkValue("stall", bus.stall, loadUse | hd);
    checkValue("alu_a", bus.alu_a, f1);
    checkValue("alu_b", bus.alu_b, cur.alu_src ? cur.imm : f2);
    checkValue("store_data", bus.ex_store_data, f2);
    if (fl) nxt = '0;
    else if (hd) nxt = cur;
    else if (loadUse) nxt = '0;
    else nxt = s;
    sbQueue.push_back(nxt);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    ex_t ld, addi, hx;
    cur = '0;
    reset = 1'b1;
    setFwd(5'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0);
    bus.id_valid = 0; bus.id_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_alu_op = 0;
    bus.id_alu_src = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.id_mem_to_reg = 0; bus.flush = 0; bus.hold = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkValue("rst_ex_valid", bus.ex_valid, 1'b0);
    checkValue("rst_alu_op", bus.alu_op, 4'b0000);
    checkValue("rst_stall", bus.stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bus.hold = 1'b0;

    $display("[TB] plain pass");
    applyStimulus(mkInstr(1, 5'd3, 5'd1, 5'd2, 64'd5, 64'd7, 64'd0, 4'b0010, 0, 1, 0, 0, 0), 0, 0);
    checkValue("plain_alu_a", bus.alu_a, 64'd5);
    checkValue("plain_alu_b", bus.alu_b, 64'd7);
    checkValue("plain_alu_op", bus.alu_op, 4'b0010);

    $display("[TB] dual forward");
    applyStimulus(mkInstr(1, 5'd4, 5'd3, 5'd4, 64'h11, 64'h22, 64'd0, 4'b0110, 0, 1, 0, 0, 0), 0, 0);
    setFwd(5'd3, 1'b1, 64'hAA, 5'd3, 1'b1, 64'hBB);
    #1;
    checkValue("dual_exmem", bus.alu_a, 64'hAA);
    bus.exmem_reg_write = 1'b0;
    #1;
    checkValue("dual_memwb", bus.alu_a, 64'hBB);

    $display("[TB] x0 guard");
    applyStimulus(mkInstr(1, 5'd7, 5'd0, 5'd2, 64'd0, 64'd9, 64'd0, 4'b0001, 0, 1, 0, 0, 0), 0, 0);
    setFwd(5'd0, 1'b1, 64'h55, 5'd0, 1'b1, 64'h66);
    #1;
    checkValue("x0_alu_a", bus.alu_a, 64'd0);

    $display("[TB] load-use");
    setFwd(5'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0);
    ld   = mkInstr(1, 5'd5, 5'd1, 5'd0, 64'd100, 64'd0, 64'd8, 4'b0010, 1, 1, 1, 0, 1);
    addi = mkInstr(1, 5'd6, 5'd5, 5'd1, 64'hDEAD, 64'd3, 64'd0, 4'b0010, 0, 1, 0, 0, 0);
    applyStimulus(ld, 0, 0);
    checkValue("ld_alu_b_imm", bus.alu_b, 64'd8);
    applyStimulus(addi, 0, 0);
    checkValue("lu_bubble", bus.ex_valid, 1'b0);
    applyStimulus(addi, 0, 0);
    setFwd(5'd0, 1'b0, 64'd0, 5'd5, 1'b1, 64'h77);
    #1;
    checkValue("lu_memwb_a", bus.alu_a, 64'h77);
    checkValue("lu_alu_b", bus.alu_b, 64'd3);

    $display("[TB] flush and hold");
    setFwd(5'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0);
    applyStimulus(mkInstr(1, 5'd9, 5'd2, 5'd3, 64'd1, 64'd2, 64'd0, 4'b1100, 0, 1, 0, 0, 0), 1, 1);
    checkValue("flush_hold_bubble", bus.ex_valid, 1'b0);
    applyStimulus(mkInstr(1, 5'd10, 5'd2, 5'd3, 64'd1, 64'd2, 64'd0, 4'b1111, 0, 1, 0, 0, 0), 0, 0);
    hx = mkInstr(1, 5'd12, 5'd4, 5'd5, 64'd9, 64'd9, 64'd0, 4'b0000, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(hx, 0, 1);
    checkValue("hold_rd", bus.ex_rd, 5'd10);
    checkValue("hold_op", bus.alu_op, 4'b1111);

    $display("[TB] mid-stream reset");
    applyStimulus(mkInstr(1, 5'd11, 5'd1, 5'd2, 64'd4, 64'd4, 64'd0, 4'b0010, 0, 1, 0, 0, 0), 0, 0);
    bus.hold = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkValue("midrst_ex_valid", bus.ex_valid, 1'b0);
    checkValue("midrst_reg_write", bus.ex_reg_write, 1'b0);
    checkValue("midrst_alu_op", bus.alu_op, 4'b0000);
    checkValue("midrst_stall", bus.stall, 1'b0);
    cur = '0;
    sbQueue.delete();
    @(negedge clk);
    reset = 1'b0;
    bus.hold = 1'b0;
    applyStimulus(mkInstr(1, 5'd13, 5'd1, 5'd2, 64'd20, 64'd30, 64'd0, 4'b0010, 0, 1, 0, 0, 0), 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 30; i++) begin
      setFwd(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
      applyStimulus(mkInstr(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
                            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule
